// File: rtl/dtc_feature_driver.sv
// dtc_feature_driver
// Initiator side of a decision-tree classifier link. It collects one feature
// vector per frame from a serial bit stream, LSB first. It presents the vector
// in parallel to a combinational classifier and registers the class it returns.
// It then offers that class downstream on a valid/ready handshake. Malformed
// frames (too short or too long) produce an error result and bump a
// saturating error counter.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     serial feature-bit handshake
//   s_bit, s_last       feature bit, end-of-frame marker
//   feat_o              assembled feature vector to the classifier input
//   cls_i               class code from the classifier (combinational of feat_o)
//   m_valid/m_ready     result handshake
//   m_class, m_err      registered class code, malformed-frame flag
//   err_cnt             saturating count of malformed frames
module dtc_feature_driver #(
  parameter int N_FEAT = 12,
  parameter int N_CLS  = 3,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_bit,
  input  logic              s_last,
  output logic [N_FEAT-1:0] feat_o,
  input  logic [N_CLS-1:0]  cls_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_CLS-1:0]  m_class,
  output logic              m_err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             beat;
  logic             frame_err;

  // Only the collecting states take serial input; while a result is being
  // produced or held, the stream is stalled.
  assign s_ready = (state == COLLECT) || (state == DRAIN);
  assign beat    = s_valid && s_ready;

  // A frame is malformed when it ends early in COLLECT, or when it ends after
  // overrunning the vector width (the tail is swallowed in DRAIN).
  assign frame_err = beat && s_last &&
                     (((state == COLLECT) && (cnt != LAST_IDX)) || (state == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      cnt     <= '0;
      feat_o  <= '0;
      m_valid <= 1'b0;
      m_class <= '0;
      m_err   <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (frame_err) begin
        state   <= HOLD;
        m_class <= '0;
        m_err   <= 1'b1;
        m_valid <= 1'b1;
        if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end

      case (state)
        COLLECT: begin
          if (beat) begin
            feat_o[cnt] <= s_bit;
            if (s_last) begin
              // Exact-length frame goes to EVAL; short frames handled above.
              if (cnt == LAST_IDX) begin
                state <= EVAL;
              end
            end else if (cnt == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          // Surplus beats are consumed without touching feat_o; the frame
          // end is handled by frame_err.
        end

        EVAL: begin
          // feat_o has been stable for this whole cycle, so cls_i is settled.
          m_class <= cls_i;
          m_err   <= 1'b0;
          m_valid <= 1'b1;
          state   <= HOLD;
        end

        HOLD: begin
          // m_valid is always set here, so m_ready alone completes the handshake.
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            feat_o  <= '0;
            state   <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_feature_driver.sv
// Self-checking bench for dtc_feature_driver. A frame-level model predicts
// each result (class, error flag, error count, feature vector) when the frame
// is sent. A monitor compares every cycle in which m_valid is high against
// the oldest outstanding prediction. Directed literal checks pin the model.
module tb_dtc_feature_driver;

  localparam int N_FEAT = 12;
  localparam int N_CLS  = 3;
  localparam int ERR_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic              s_bit;
  logic              s_last;
  logic [N_FEAT-1:0] feat_o;
  logic [N_CLS-1:0]  cls_i;
  logic              m_valid;
  logic              m_ready;
  logic [N_CLS-1:0]  m_class;
  logic              m_err;
  logic [ERR_W-1:0]  err_cnt;

  dtc_feature_driver #(.N_FEAT(N_FEAT), .N_CLS(N_CLS), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_bit   (s_bit),
    .s_last  (s_last),
    .feat_o  (feat_o),
    .cls_i   (cls_i),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
    .m_err   (m_err),
    .err_cnt (err_cnt)
  );

  // Stand-in classifier.
  assign cls_i = feat_o[2:0] ^ feat_o[5:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cls;
    logic        err;
    logic [11:0] feat;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   model_err;
  int   pass_cnt;
  int   total_cnt;
  bit   mon_en;
  int   frame_no;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: exactly N_FEAT bits is a good frame, anything else is
  // malformed and bumps the saturating counter.
  task automatic predict(input logic [15:0] bits, input int len);
    exp_t e;
    if (len == N_FEAT) begin
      e.cls  = bits[2:0] ^ bits[5:3];
      e.err  = 1'b0;
      e.feat = bits[11:0];
    end else begin
      e.cls  = 3'd0;
      e.err  = 1'b1;
      e.feat = 12'd0;
      if (model_err < 255) model_err++;
    end
    e.ecnt = 8'(model_err);
    exp_q.push_back(e);
  endtask

  // Sends one frame LSB first with s_last on the final beat, then checks
  // result latency: error results appear right after the last beat, and good
  // results appear one cycle later (after EVAL).
  task automatic send_frame(input logic [15:0] bits, input int len, input int gap_max);
    int g;
    for (int k = 0; k < 50 && !s_ready; k++) tick;
    check("ready_wait", {31'd0, s_ready}, 32'd1);
    predict(bits, len);
    for (int i = 0; i < len; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        s_valid = 1'b0;
        tick;
      end
      s_valid = 1'b1;
      s_bit   = bits[i];
      s_last  = (i == len - 1);
      tick;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    frame_no++;
    if (len == N_FEAT) begin
      check("eval_no_valid", {31'd0, m_valid}, 32'd0);
      check("eval_no_ready", {31'd0, s_ready}, 32'd0);
      tick;
      check("good_latency", {31'd0, m_valid}, 32'd1);
    end else begin
      check("err_latency", {31'd0, m_valid}, 32'd1);
    end
    $display("frame %0d len=%0d bits=%h m_class=%0d m_err=%0d err_cnt=%0d",
             frame_no, len, bits, m_class, m_err, err_cnt);
  endtask

  // Compare process: every cycle a result is offered it must match the
  // oldest prediction; the prediction retires on the handshake.
  always @(negedge clk) begin
    if (rst_n && mon_en && m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q[0];
        check("m_class", {29'd0, m_class}, {29'd0, mon_e.cls});
        check("m_err", {31'd0, m_err}, {31'd0, mon_e.err});
        check("err_cnt", {24'd0, err_cnt}, {24'd0, mon_e.ecnt});
        if (!mon_e.err) check("feat_o", {20'd0, feat_o}, {20'd0, mon_e.feat});
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    model_err = 0;
    frame_no  = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_bit     = 1'b0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_feat", {20'd0, feat_o}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_m_class", {29'd0, m_class}, 32'd0);
    mon_en = 1'b1;

    // Good frame, literal expectations.
    send_frame(16'h0A53, 12, 0);
    check("a53_feat", {20'd0, feat_o}, 32'hA53);
    check("a53_class", {29'd0, m_class}, 32'd1);
    check("a53_err", {31'd0, m_err}, 32'd0);
    tick;

    // Backpressure: result held for 10 cycles; stray beats ignored.
    m_ready = 1'b0;
    send_frame(16'h05C7, 12, 0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_bit   = 1'b1;
      s_last  = 1'b1;
      check("bp_valid", {31'd0, m_valid}, 32'd1);
      check("bp_s_ready", {31'd0, s_ready}, 32'd0);
      check("bp_class", {29'd0, m_class}, 32'd7);
      tick;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    tick;
    check("bp_release_valid", {31'd0, m_valid}, 32'd0);
    check("bp_release_ready", {31'd0, s_ready}, 32'd1);
    check("bp_release_feat", {20'd0, feat_o}, 32'd0);
    check("bp_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Short frame: s_last on the 7th beat.
    send_frame(16'h007F, 7, 0);
    check("short_class", {29'd0, m_class}, 32'd0);
    check("short_err", {31'd0, m_err}, 32'd1);
    check("short_err_cnt", {24'd0, err_cnt}, 32'd1);
    tick;
    send_frame(16'h00F0, 12, 0);
    check("after_short_class", {29'd0, m_class}, 32'd6);
    check("after_short_err", {31'd0, m_err}, 32'd0);
    tick;

    // One-bit frame is a short frame.
    send_frame(16'h0001, 1, 0);
    check("one_bit_err", {31'd0, m_err}, 32'd1);
    check("one_bit_cnt", {24'd0, err_cnt}, 32'd2);
    tick;

    // Long frame: 15 beats, surplus discarded.
    send_frame(16'h7ABC, 15, 0);
    check("long_err", {31'd0, m_err}, 32'd1);
    check("long_err_cnt", {24'd0, err_cnt}, 32'd3);
    check("long_feat", {20'd0, feat_o}, 32'hABC);
    tick;

    // Saturation.
    for (int f = 0; f < 300; f++) begin
      send_frame(16'(f * 37), 15, 0);
      tick;
    end
    check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_bit   = 1'b1;
      s_last  = 1'b0;
      tick;
    end
    s_valid = 1'b0;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_feat", {20'd0, feat_o}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    exp_q.delete();
    model_err = 0;
    tick;
    rst_n = 1'b1;
    tick;
    mon_en = 1'b1;
    send_frame(16'h03C5, 12, 0);
    check("post_rst_class", {29'd0, m_class}, 32'd5);
    check("post_rst_err", {31'd0, m_err}, 32'd0);
    tick;

    // Back-to-back frames with random gaps.
    for (int f = 0; f < 20; f++) begin
      int sel;
      int len;
      sel = int'($urandom_range(4, 0));
      len = (sel == 3) ? 7 : (sel == 4) ? 14 : 12;
      send_frame(16'($urandom), len, 3);
    end

    repeat (5) tick;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
